// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and
// instruction-size constants.
package instruction_fetch_unit_pkg;

   // Fetch FSM: RUN = idle bus, WAIT = live request outstanding,
   // DROP = outstanding request whose response will be thrown away.
   typedef enum logic [1:0] {
      StRun  = 2'd0,
      StWait = 2'd1,
      StDrop = 2'd2
   } fetch_state_e;

   // Instructions are 4 bytes; fetch addresses are always word aligned.
   localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} pairs. The head is presented
// combinationally from storage; flush empties it in one cycle.
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   // Next-state for storage, pointers and occupancy; flush dominates.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Guard against overflow/underflow even if the caller misbehaves.
      push_ok  = push && (count_q < CNT_W'(DEPTH));
      pop_ok   = pop && (count_q != '0);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   // State registers; storage is cleared so the head reads zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC sequencing, single-outstanding imem request
// handshake, prefetch buffering and redirect/flush handling.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_data,
   input  logic            inst_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_idle
);

   localparam int unsigned     CNT_W      = $clog2(DEPTH) + 1;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSN_BYTES - 1);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSN_BYTES);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            req_q, req_d;

   logic             fifo_push, fifo_pop;
   logic [CNT_W-1:0] fifo_count, count_next;
   logic [2*XLEN-1:0] fifo_head;
   logic             granted;

   fetch_fifo #(
      .WIDTH (2 * XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data ({req_pc_q, imem_rdata}),
      .pop       (fifo_pop),
      .flush     (redirect_valid),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   // FSM next-state, PC sequencing and FIFO push/pop decisions.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      fifo_push  = 1'b0;
      // A flush overrides any pop in the same cycle.
      fifo_pop   = (fifo_count != '0) && inst_ready && !redirect_valid;
      // req_q is only ever high in RUN, so a grant implies RUN.
      granted    = req_q && imem_gnt;

      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ALIGN_MASK;
         unique case (state_q)
            StRun:   state_d = granted ? StDrop : StRun;
            // The response for the old stream either lands now (discarded,
            // bus free again) or is still coming and must be dropped.
            StWait:  state_d = imem_rvalid ? StRun : StDrop;
            StDrop:  state_d = imem_rvalid ? StRun : StDrop;
            default: state_d = StRun;
         endcase
      end else begin
         unique case (state_q)
            StRun: begin
               if (granted) begin
                  fetch_pc_d = fetch_pc_q + PC_STEP;
                  req_pc_d   = fetch_pc_q;
                  state_d    = StWait;
               end
            end
            StWait: begin
               if (imem_rvalid) begin
                  fifo_push = 1'b1;
                  state_d   = StRun;
               end
            end
            StDrop: begin
               if (imem_rvalid) begin
                  state_d = StRun;
               end
            end
            default: state_d = StRun;
         endcase
      end

      count_next = redirect_valid ? '0
                                  : fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
      // Request only from RUN and only with room left, so a granted fetch
      // always has a FIFO slot when its data returns.
      req_d = (state_d == StRun) && (count_next < CNT_W'(DEPTH));
   end

   // FSM, PC and registered request state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StRun;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         req_q      <= req_d;
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = fetch_pc_q;
   assign inst_valid = (fifo_count != '0);
   assign inst_pc    = fifo_head[2*XLEN-1:XLEN];
   assign inst_data  = fifo_head[XLEN-1:0];
   assign fetch_idle = (state_q == StRun) && (fifo_count == '0) && !req_q;

`ifndef SYNTHESIS
   // Until the first post-reset grant, a stray rvalid may belong to a
   // request issued before reset, so only flag it once armed.
   logic armed_q;

   // Arm the protocol check on the first grant after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q <= 1'b0;
      end else if (req_q && imem_gnt) begin
         armed_q <= 1'b1;
      end
   end

   // rvalid with nothing outstanding is a memory protocol violation.
   always_ff @(posedge clk) begin
      if (rst_n && armed_q) begin
         assert (!(imem_rvalid && (state_q == StRun)))
         else $error("imem_rvalid with no outstanding request");
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed + randomized bench for instruction_fetch_unit. A behavioural
// memory tracks its own expected fetch address and pushes {pc, data} to a
// scoreboard when it returns live data; the consumer pops and compares.
module tb_instruction_fetch_unit;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        inst_valid;
   logic [31:0] inst_pc;
   logic [31:0] inst_data;
   logic        inst_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        fetch_idle;

   instruction_fetch_unit #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_pc        (inst_pc),
      .inst_data      (inst_data),
      .inst_ready     (inst_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_idle     (fetch_idle)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboard of {pc, data} in the order the core must see them.
   logic [63:0] sb_q[$];

   // Memory / reference model state.
   logic [31:0] next_addr = RESET_PC;
   logic [31:0] pend_pc = '0;
   bit          pending = 0;
   bit          pend_stale = 0;
   bit          granted_now = 0;
   int          rv_cnt = 0;
   int          gnt_wait = 0;
   int          gnt_dly = 0;
   int          rv_dly = 0;
   bit          rand_dly = 0;
   int          n_consumed = 0;
   bit          ready_drv = 0;
   bit          redir_drv = 0;
   logic [31:0] redir_target = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      sb_q.delete();
      next_addr  = RESET_PC;
      pending    = 0;
      pend_stale = 0;
      gnt_wait   = 0;
      redir_drv  = 0;
   endtask

   // One clock: at the falling edge, decide memory/core/redirect inputs for
   // the next rising edge and check the current head if it is consumed.
   task automatic step();
      logic [63:0] e;
      bit          delivered;
      @(negedge clk);
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      inst_ready     = 1'b0;
      granted_now    = 0;
      delivered      = 0;
      if (!rst_n) return;

      if (pending) begin
         if (rv_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_pc ^ KEY;
            if (!pend_stale && !redir_drv) sb_q.push_back({pend_pc, pend_pc ^ KEY});
            pending   = 0;
            delivered = 1;
         end else begin
            rv_cnt--;
         end
      end

      if (imem_req === 1'b1 && !pending && !delivered) begin
         if (gnt_wait >= gnt_dly) begin
            imem_gnt = 1'b1;
            check("grant_addr", imem_addr, next_addr);
            pending     = 1;
            pend_stale  = 0;
            pend_pc     = next_addr;
            next_addr   = next_addr + 32'd4;
            rv_cnt      = rand_dly ? int'($urandom_range(0, 4)) : rv_dly;
            gnt_wait    = 0;
            granted_now = 1;
            if (rand_dly) gnt_dly = int'($urandom_range(0, 5));
         end else begin
            gnt_wait++;
         end
      end

      inst_ready = ready_drv;
      if (ready_drv && !redir_drv && inst_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("spurious_inst_valid", {31'b0, inst_valid}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("inst_pc", inst_pc, e[63:32]);
            check("inst_data", inst_data, e[31:0]);
            n_consumed++;
         end
      end

      if (redir_drv) begin
         redirect_valid = 1'b1;
         redirect_pc    = redir_target;
         sb_q.delete();
         if (pending) pend_stale = 1;
         next_addr = redir_target & 32'hFFFF_FFFC;
         redir_drv = 0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_model();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_grant(output bit ok);
      ok = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (granted_now) begin
            ok = 1;
            return;
         end
      end
   endtask

   initial begin
      bit ok;
      int c0;
      int c1;

      // Reset values
      clear_model();
      step();
      step();
      check("rst_imem_req", {31'b0, imem_req}, 32'd0);
      check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
      check("rst_fetch_idle", {31'b0, fetch_idle}, 32'd1);
      check("rst_imem_addr", imem_addr, RESET_PC);
      rst_n = 1'b1;

      // Streaming with single-cycle memory: one instruction per 2 cycles
      ready_drv = 1;
      repeat (10) step();
      c1 = n_consumed;
      repeat (20) step();
      check("throughput", 32'(n_consumed - c1), 32'd10);

      // Backpressure: FIFO fills to DEPTH and requests stop
      do_reset();
      ready_drv = 0;
      repeat (20) step();
      check("full_imem_req", {31'b0, imem_req}, 32'd0);
      check("full_inst_valid", {31'b0, inst_valid}, 32'd1);
      check("full_head_pc", inst_pc, 32'h0);
      ready_drv = 1;
      step();
      ready_drv = 0;
      step();
      check("after_pop_req", {31'b0, imem_req}, 32'd1);
      check("after_pop_addr", imem_addr, 32'h10);
      check("after_pop_head", inst_pc, 32'h4);

      // Redirect while WAIT: stale response must not reach the FIFO
      do_reset();
      ready_drv = 0;
      rv_dly = 2;
      wait_grant(ok);
      check("wait_grant_1", {31'b0, ok}, 32'd1);
      step();
      redir_target = 32'h40;
      redir_drv = 1;
      step();
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (inst_valid === 1'b1) begin
            ok = 1;
            break;
         end
      end
      check("redir_data_seen", {31'b0, ok}, 32'd1);
      check("redir_head_pc", inst_pc, 32'h40);
      check("redir_head_data", inst_data, 32'h40 ^ KEY);

      // Unaligned redirect target is forced to a word boundary
      do_reset();
      ready_drv = 0;
      rv_dly = 0;
      repeat (16) step();
      redir_target = 32'h43;
      redir_drv = 1;
      step();
      step();
      check("align_addr", imem_addr, 32'h40);
      check("align_req", {31'b0, imem_req}, 32'd1);
      check("align_flushed", {31'b0, inst_valid}, 32'd0);

      // Redirect coinciding with rvalid and with a pop
      rv_dly = 1;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (granted_now && sb_q.size() >= 2) begin
            ok = 1;
            break;
         end
      end
      check("coinc_setup", {31'b0, ok}, 32'd1);
      step();
      ready_drv = 1;
      redir_target = 32'h80;
      redir_drv = 1;
      step();
      ready_drv = 0;
      step();
      check("coinc_empty", {31'b0, inst_valid}, 32'd0);
      check("coinc_req", {31'b0, imem_req}, 32'd1);
      check("coinc_addr", imem_addr, 32'h80);

      // PC wraps modulo 2^XLEN
      ready_drv = 1;
      rv_dly = 0;
      redir_target = 32'hFFFF_FFF9;
      redir_drv = 1;
      step();
      c0 = n_consumed;
      for (int i = 0; i < 40 && n_consumed < c0 + 3; i++) step();
      check("wrap_consumed", 32'(n_consumed - c0), 32'd3);

      // Random delays, backpressure and redirects
      do_reset();
      rand_dly = 1;
      c0 = n_consumed;
      for (int i = 0; i < 1500; i++) begin
         ready_drv = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 24) == 0) begin
            redir_drv = 1;
            redir_target = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                       : 32'($urandom_range(0, 1023));
         end
         step();
      end
      check("random_progress", {31'b0, (n_consumed - c0) > 50}, 32'd1);
      rand_dly = 0;
      gnt_dly = 0;

      // Reset mid-WAIT, then a late response for the pre-reset request
      do_reset();
      ready_drv = 0;
      rv_dly = 3;
      wait_grant(ok);
      check("wait_grant_2", {31'b0, ok}, 32'd1);
      step();
      rst_n = 1'b0;
      #1;
      check("midrst_req", {31'b0, imem_req}, 32'd0);
      check("midrst_valid", {31'b0, inst_valid}, 32'd0);
      check("midrst_pc", inst_pc, 32'd0);
      check("midrst_data", inst_data, 32'd0);
      check("midrst_idle", {31'b0, fetch_idle}, 32'd1);
      clear_model();
      step();
      step();
      rst_n = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      check("late_rv_valid", {31'b0, inst_valid}, 32'd0);
      check("late_rv_req", {31'b0, imem_req}, 32'd1);
      check("late_rv_addr", imem_addr, RESET_PC);
      ready_drv = 1;
      c0 = n_consumed;
      for (int i = 0; i < 20 && n_consumed == c0; i++) step();
      check("late_rv_first", 32'(n_consumed - c0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
